// File: rtl/dcache_mshr.sv
// dcache_mshr: miss status holding registers between the dcache and memory.
// Ports: miss_* request in, proc2mem_*/mem2proc_* memory side,
//        mshr2Dcache_* fill out, dcache_wr_ready grant, mshr_empty.
// Option: DCACHE_MSHR_FWD_EN enables zero-cycle fill of returning data.
package dcache_mshr_pkg;
  typedef enum logic [1:0] {
    EMPTY      = 2'd0,
    WAIT_ISSUE = 2'd1,
    WAIT_DATA  = 2'd2,
    READY      = 2'd3
  } mshr_state_e;

  localparam logic [1:0] MEM_NONE = 2'd0;
  localparam logic [1:0] MEM_LOAD = 2'd1;

  typedef struct packed {
    mshr_state_e state;
    logic [31:0] addr;
    logic        is_store;
    logic [1:0]  st_size;
    logic [31:0] st_data;
    logic [3:0]  tag;
    logic [63:0] block;
  } mshr_entry_t;
endpackage

module dcache_mshr
  import dcache_mshr_pkg::*;
#(
  parameter int MSHR_ENTRIES = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        miss_valid,
  input  logic [31:0] miss_addr,
  input  logic        miss_is_store,
  input  logic [1:0]  miss_st_size,
  input  logic [31:0] miss_st_data,
  output logic        miss_ready,
  output logic [1:0]  proc2mem_command,
  output logic [31:0] proc2mem_addr,
  input  logic [3:0]  mem2proc_transaction_tag,
  input  logic [3:0]  mem2proc_data_tag,
  input  logic [63:0] mem2proc_data,
  output logic        mshr2Dcache_wr,
  output logic [63:0] mshr2Dcache_mem_block,
  output logic [31:0] mshr2Dcache_addr,
  output logic        mshr2Dcache_is_store,
  output logic [1:0]  mshr2Dcache_st_size,
  output logic [31:0] mshr2Dcache_st_data,
  input  logic        dcache_wr_ready,
  output logic        mshr_empty
);

  localparam int IW = $clog2(MSHR_ENTRIES);

  mshr_entry_t ent [MSHR_ENTRIES];

  logic          any_empty;
  logic          all_empty;
  logic          dup_hit;
  logic          issue_vld;
  logic          cap_vld;
  logic          fill_vld;
  logic [IW-1:0] alloc_idx;
  logic [IW-1:0] issue_idx;
  logic [IW-1:0] cap_idx;
  logic [IW-1:0] fill_idx;
  logic          accept;
  logic          issue_ok;
  logic          fill_done;
  logic          fwd;
  logic          dtag_nz;

  assign dtag_nz = (mem2proc_data_tag != 4'd0);

  // Scan high to low so the lowest matching index wins.
  // Capture only looks at registered WAIT_DATA entries, so a tag
  // being handed out this cycle can never be captured by its new owner.
  always_comb begin
    any_empty = 1'b0;
    all_empty = 1'b1;
    dup_hit   = 1'b0;
    issue_vld = 1'b0;
    cap_vld   = 1'b0;
    fill_vld  = 1'b0;
    alloc_idx = '0;
    issue_idx = '0;
    cap_idx   = '0;
    fill_idx  = '0;
    for (int i = MSHR_ENTRIES - 1; i >= 0; i--) begin
      if (ent[i].state == EMPTY) begin
        any_empty = 1'b1;
        alloc_idx = IW'(i);
      end else begin
        all_empty = 1'b0;
        if (ent[i].addr[31:3] == miss_addr[31:3])
          dup_hit = 1'b1;
      end
      if (ent[i].state == WAIT_ISSUE) begin
        issue_vld = 1'b1;
        issue_idx = IW'(i);
      end
      if (ent[i].state == WAIT_DATA && dtag_nz &&
          ent[i].tag == mem2proc_data_tag) begin
        cap_vld = 1'b1;
        cap_idx = IW'(i);
      end
      if (ent[i].state == READY) begin
        fill_vld = 1'b1;
        fill_idx = IW'(i);
      end
    end
  end

  assign miss_ready = any_empty && !dup_hit;
  assign mshr_empty = all_empty;
  assign accept     = miss_valid && miss_ready;

  assign issue_ok =
    issue_vld && (mem2proc_transaction_tag != 4'd0);

  assign proc2mem_command = issue_vld ? MEM_LOAD : MEM_NONE;
  assign proc2mem_addr    = issue_vld ?
    {ent[issue_idx].addr[31:3], 3'b000} : 32'd0;

`ifdef DCACHE_MSHR_FWD_EN
  // Bypass READY only when the fill port is otherwise idle and granted.
  assign fwd = !fill_vld && cap_vld && dcache_wr_ready;
`else
  assign fwd = 1'b0;
`endif

  assign fill_done = fill_vld && dcache_wr_ready;

  always_comb begin
    mshr2Dcache_wr        = 1'b0;
    mshr2Dcache_mem_block = 64'd0;
    mshr2Dcache_addr      = 32'd0;
    mshr2Dcache_is_store  = 1'b0;
    mshr2Dcache_st_size   = 2'd0;
    mshr2Dcache_st_data   = 32'd0;
    unique case (1'b1)
      fill_vld: begin
        mshr2Dcache_wr        = 1'b1;
        mshr2Dcache_mem_block = ent[fill_idx].block;
        mshr2Dcache_addr      = ent[fill_idx].addr;
        mshr2Dcache_is_store  = ent[fill_idx].is_store;
        mshr2Dcache_st_size   = ent[fill_idx].st_size;
        mshr2Dcache_st_data   = ent[fill_idx].st_data;
      end
      fwd: begin
        mshr2Dcache_wr        = 1'b1;
        mshr2Dcache_mem_block = mem2proc_data;
        mshr2Dcache_addr      = ent[cap_idx].addr;
        mshr2Dcache_is_store  = ent[cap_idx].is_store;
        mshr2Dcache_st_size   = ent[cap_idx].st_size;
        mshr2Dcache_st_data   = ent[cap_idx].st_data;
      end
      default: ;
    endcase
  end

  // Accept, issue, capture and fill always target entries in
  // different states, so their updates never collide.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < MSHR_ENTRIES; i++)
        ent[i] <= '0;
    end else begin
      if (accept) begin
        ent[alloc_idx].state    <= WAIT_ISSUE;
        ent[alloc_idx].addr     <= miss_addr;
        ent[alloc_idx].is_store <= miss_is_store;
        ent[alloc_idx].st_size  <= miss_st_size;
        ent[alloc_idx].st_data  <= miss_st_data;
        ent[alloc_idx].tag      <= 4'd0;
        ent[alloc_idx].block    <= 64'd0;
      end
      if (issue_ok) begin
        ent[issue_idx].state <= WAIT_DATA;
        ent[issue_idx].tag   <= mem2proc_transaction_tag;
      end
      if (cap_vld) begin
        ent[cap_idx].state <= fwd ? EMPTY : READY;
        ent[cap_idx].block <= mem2proc_data;
      end
      if (fill_done)
        ent[fill_idx].state <= EMPTY;
    end
  end

endmodule

// File: tb/tb_dcache_mshr.sv
// tb_dcache_mshr: directed scenarios plus a randomized run
// against a behavioural model of the miss entries and memory.
module tb_dcache_mshr;
  localparam int N = 4;
`ifdef DCACHE_MSHR_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif
  localparam int S_FREE  = 0;
  localparam int S_ISSUE = 1;
  localparam int S_DATA  = 2;
  localparam int S_READY = 3;

  logic        clock;
  logic        reset;
  logic        miss_valid;
  logic [31:0] miss_addr;
  logic        miss_is_store;
  logic [1:0]  miss_st_size;
  logic [31:0] miss_st_data;
  logic        miss_ready;
  logic [1:0]  proc2mem_command;
  logic [31:0] proc2mem_addr;
  logic [3:0]  mem2proc_transaction_tag;
  logic [3:0]  mem2proc_data_tag;
  logic [63:0] mem2proc_data;
  logic        mshr2Dcache_wr;
  logic [63:0] mshr2Dcache_mem_block;
  logic [31:0] mshr2Dcache_addr;
  logic        mshr2Dcache_is_store;
  logic [1:0]  mshr2Dcache_st_size;
  logic [31:0] mshr2Dcache_st_data;
  logic        dcache_wr_ready;
  logic        mshr_empty;

  int checks = 0;
  int fails  = 0;

  int          ms [N];
  logic [31:0] ma [N];
  logic        mst[N];
  logic [1:0]  msz[N];
  logic [31:0] msd[N];
  logic [3:0]  mt [N];
  logic [63:0] mb [N];

  dcache_mshr #(.MSHR_ENTRIES(N)) dut (
    .clock(clock),
    .reset(reset),
    .miss_valid(miss_valid),
    .miss_addr(miss_addr),
    .miss_is_store(miss_is_store),
    .miss_st_size(miss_st_size),
    .miss_st_data(miss_st_data),
    .miss_ready(miss_ready),
    .proc2mem_command(proc2mem_command),
    .proc2mem_addr(proc2mem_addr),
    .mem2proc_transaction_tag(mem2proc_transaction_tag),
    .mem2proc_data_tag(mem2proc_data_tag),
    .mem2proc_data(mem2proc_data),
    .mshr2Dcache_wr(mshr2Dcache_wr),
    .mshr2Dcache_mem_block(mshr2Dcache_mem_block),
    .mshr2Dcache_addr(mshr2Dcache_addr),
    .mshr2Dcache_is_store(mshr2Dcache_is_store),
    .mshr2Dcache_st_size(mshr2Dcache_st_size),
    .mshr2Dcache_st_data(mshr2Dcache_st_data),
    .dcache_wr_ready(dcache_wr_ready),
    .mshr_empty(mshr_empty)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic idle();
    miss_valid = 1'b0;
    miss_addr = 32'd0;
    miss_is_store = 1'b0;
    miss_st_size = 2'd0;
    miss_st_data = 32'd0;
    mem2proc_transaction_tag = 4'd0;
    mem2proc_data_tag = 4'd0;
    mem2proc_data = 64'd0;
    dcache_wr_ready = 1'b1;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    idle();
    tick();
    tick();
    reset = 1'b1;
  endtask

  task automatic load_miss(input logic [31:0] a);
    idle();
    miss_valid = 1'b1;
    miss_addr = a;
  endtask

  function automatic bit held(input logic [3:0] t);
    for (int i = 0; i < N; i++)
      if (ms[i] == S_DATA && mt[i] == t) return 1'b1;
    return 1'b0;
  endfunction

  task automatic test_reset();
    reset = 1'b0;
    idle();
    miss_valid = 1'b1;
    miss_addr = 32'h0000_0040;
    mem2proc_data_tag = 4'd1;
    @(negedge clock);
    checks++; if (miss_ready !== 1'b1) begin fails++; $display("FAIL reset_miss_ready got %0b want 1", miss_ready); end
    checks++; if (mshr_empty !== 1'b1) begin fails++; $display("FAIL reset_empty got %0b want 1", mshr_empty); end
    checks++; if (proc2mem_command !== 2'd0) begin fails++; $display("FAIL reset_cmd got %0d want 0", proc2mem_command); end
    checks++; if (proc2mem_addr !== 32'd0) begin fails++; $display("FAIL reset_paddr got %h want 0", proc2mem_addr); end
    checks++; if (mshr2Dcache_wr !== 1'b0) begin fails++; $display("FAIL reset_wr got %0b want 0", mshr2Dcache_wr); end
    checks++; if (mshr2Dcache_mem_block !== 64'd0) begin fails++; $display("FAIL reset_block got %h want 0", mshr2Dcache_mem_block); end
    tick();
    @(negedge clock);
    checks++; if (mshr_empty !== 1'b1) begin fails++; $display("FAIL reset_hold_empty got %0b want 1", mshr_empty); end
    checks++; if (proc2mem_command !== 2'd0) begin fails++; $display("FAIL reset_hold_cmd got %0d want 0", proc2mem_command); end
    tick();
  endtask

  task automatic test_single_load();
    do_reset();
    load_miss(32'h0000_1004);
    @(negedge clock);
    checks++; if (miss_ready !== 1'b1) begin fails++; $display("FAIL single_ready got %0b want 1", miss_ready); end
    tick();
    idle();
    mem2proc_transaction_tag = 4'd3;
    @(negedge clock);
    checks++; if (proc2mem_command !== 2'd1) begin fails++; $display("FAIL single_cmd got %0d want 1", proc2mem_command); end
    checks++; if (proc2mem_addr !== 32'h1000) begin fails++; $display("FAIL single_paddr got %h want 1000", proc2mem_addr); end
    tick();
    idle();
    @(negedge clock);
    checks++; if (proc2mem_command !== 2'd0) begin fails++; $display("FAIL single_cmd_after got %0d want 0", proc2mem_command); end
    checks++; if (mshr2Dcache_wr !== 1'b0) begin fails++; $display("FAIL single_wr_early got %0b want 0", mshr2Dcache_wr); end
    tick();
    mem2proc_data_tag = 4'd3;
    mem2proc_data = 64'hAABB;
    @(negedge clock);
`ifdef DCACHE_MSHR_FWD_EN
    checks++; if (mshr2Dcache_wr !== 1'b1) begin fails++; $display("FAIL single_fwd_wr got %0b want 1", mshr2Dcache_wr); end
    checks++; if (mshr2Dcache_mem_block !== 64'hAABB) begin fails++; $display("FAIL single_fwd_block got %h want aabb", mshr2Dcache_mem_block); end
    checks++; if (mshr2Dcache_addr !== 32'h1004) begin fails++; $display("FAIL single_fwd_addr got %h want 1004", mshr2Dcache_addr); end
    tick();
    idle();
`else
    checks++; if (mshr2Dcache_wr !== 1'b0) begin fails++; $display("FAIL single_wr_data_cycle got %0b want 0", mshr2Dcache_wr); end
    tick();
    idle();
    @(negedge clock);
    checks++; if (mshr2Dcache_wr !== 1'b1) begin fails++; $display("FAIL single_wr got %0b want 1", mshr2Dcache_wr); end
    checks++; if (mshr2Dcache_mem_block !== 64'hAABB) begin fails++; $display("FAIL single_block got %h want aabb", mshr2Dcache_mem_block); end
    checks++; if (mshr2Dcache_addr !== 32'h1004) begin fails++; $display("FAIL single_addr got %h want 1004", mshr2Dcache_addr); end
    checks++; if (mshr2Dcache_is_store !== 1'b0) begin fails++; $display("FAIL single_is_store got %0b want 0", mshr2Dcache_is_store); end
    tick();
`endif
    @(negedge clock);
    checks++; if (mshr_empty !== 1'b1) begin fails++; $display("FAIL single_empty got %0b want 1", mshr_empty); end
    checks++; if (mshr2Dcache_wr !== 1'b0) begin fails++; $display("FAIL single_wr_done got %0b want 0", mshr2Dcache_wr); end
  endtask

  task automatic test_four_reject();
    do_reset();
    for (int k = 0; k < 4; k++) begin
      load_miss(32'(k * 8));
      @(negedge clock);
      checks++; if (miss_ready !== 1'b1) begin fails++; $display("FAIL four_ready%0d got %0b want 1", k, miss_ready); end
      if (k > 0) begin
        checks++; if (proc2mem_command !== 2'd1 || proc2mem_addr !== 32'd0) begin fails++; $display("FAIL four_retry%0d got %0d/%h want 1/0", k, proc2mem_command, proc2mem_addr); end
      end
      tick();
    end
    for (int k = 0; k < 2; k++) begin
      load_miss(32'h20);
      @(negedge clock);
      checks++; if (miss_ready !== 1'b0) begin fails++; $display("FAIL four_full%0d got %0b want 0", k, miss_ready); end
      checks++; if (proc2mem_command !== 2'd1 || proc2mem_addr !== 32'd0) begin fails++; $display("FAIL four_rej%0d got %0d/%h want 1/0", k, proc2mem_command, proc2mem_addr); end
      tick();
    end
    for (int k = 0; k < 4; k++) begin
      idle();
      mem2proc_transaction_tag = 4'(k + 1);
      @(negedge clock);
      checks++; if (proc2mem_command !== 2'd1 || proc2mem_addr !== 32'(k * 8)) begin fails++; $display("FAIL four_order%0d got %0d/%h want 1/%h", k, proc2mem_command, proc2mem_addr, k * 8); end
      tick();
    end
    idle();
    @(negedge clock);
    checks++; if (proc2mem_command !== 2'd0) begin fails++; $display("FAIL four_idle got %0d want 0", proc2mem_command); end
  endtask

  task automatic test_out_of_order();
    do_reset();
    load_miss(32'h100);
    tick();
    load_miss(32'h208);
    mem2proc_transaction_tag = 4'd1;
    @(negedge clock);
    checks++; if (proc2mem_addr !== 32'h100) begin fails++; $display("FAIL ooo_issue0 got %h want 100", proc2mem_addr); end
    tick();
    idle();
    mem2proc_transaction_tag = 4'd2;
    @(negedge clock);
    checks++; if (proc2mem_addr !== 32'h208) begin fails++; $display("FAIL ooo_issue1 got %h want 208", proc2mem_addr); end
    tick();
    idle();
    mem2proc_data_tag = 4'd2;
    mem2proc_data = 64'h2222_0000_0000_2222;
    @(negedge clock);
`ifdef DCACHE_MSHR_FWD_EN
    checks++; if (mshr2Dcache_wr !== 1'b1 || mshr2Dcache_mem_block !== 64'h2222_0000_0000_2222 || mshr2Dcache_addr !== 32'h208) begin fails++; $display("FAIL ooo_fill_a got %0b/%h/%h want 1/2222000000002222/208", mshr2Dcache_wr, mshr2Dcache_mem_block, mshr2Dcache_addr); end
`else
    checks++; if (mshr2Dcache_wr !== 1'b0) begin fails++; $display("FAIL ooo_wr_a got %0b want 0", mshr2Dcache_wr); end
`endif
    tick();
    idle();
    mem2proc_data_tag = 4'd1;
    mem2proc_data = 64'h1111_0000_0000_1111;
    @(negedge clock);
`ifdef DCACHE_MSHR_FWD_EN
    checks++; if (mshr2Dcache_wr !== 1'b1 || mshr2Dcache_mem_block !== 64'h1111_0000_0000_1111 || mshr2Dcache_addr !== 32'h100) begin fails++; $display("FAIL ooo_fill_b got %0b/%h/%h want 1/1111000000001111/100", mshr2Dcache_wr, mshr2Dcache_mem_block, mshr2Dcache_addr); end
    tick();
    idle();
`else
    checks++; if (mshr2Dcache_wr !== 1'b1 || mshr2Dcache_mem_block !== 64'h2222_0000_0000_2222 || mshr2Dcache_addr !== 32'h208) begin fails++; $display("FAIL ooo_fill_a got %0b/%h/%h want 1/2222000000002222/208", mshr2Dcache_wr, mshr2Dcache_mem_block, mshr2Dcache_addr); end
    tick();
    idle();
    @(negedge clock);
    checks++; if (mshr2Dcache_wr !== 1'b1 || mshr2Dcache_mem_block !== 64'h1111_0000_0000_1111 || mshr2Dcache_addr !== 32'h100) begin fails++; $display("FAIL ooo_fill_b got %0b/%h/%h want 1/1111000000001111/100", mshr2Dcache_wr, mshr2Dcache_mem_block, mshr2Dcache_addr); end
    tick();
`endif
    @(negedge clock);
    checks++; if (mshr_empty !== 1'b1) begin fails++; $display("FAIL ooo_empty got %0b want 1", mshr_empty); end
  endtask

  task automatic test_duplicate();
    do_reset();
    load_miss(32'h1000);
    tick();
    idle();
    mem2proc_transaction_tag = 4'd5;
    tick();
    idle();
    miss_addr = 32'h2000;
    @(negedge clock);
    checks++; if (miss_ready !== 1'b1) begin fails++; $display("FAIL dup_other_block got %0b want 1", miss_ready); end
    for (int k = 0; k < 2; k++) begin
      load_miss(32'h1004);
      @(negedge clock);
      checks++; if (miss_ready !== 1'b0) begin fails++; $display("FAIL dup_wait%0d got %0b want 0", k, miss_ready); end
      tick();
    end
    load_miss(32'h1004);
    mem2proc_data_tag = 4'd5;
    mem2proc_data = 64'h55;
    @(negedge clock);
    checks++; if (miss_ready !== 1'b0) begin fails++; $display("FAIL dup_data_cycle got %0b want 0", miss_ready); end
    tick();
    load_miss(32'h1004);
`ifndef DCACHE_MSHR_FWD_EN
    @(negedge clock);
    checks++; if (miss_ready !== 1'b0) begin fails++; $display("FAIL dup_fill_cycle got %0b want 0", miss_ready); end
    tick();
`endif
    @(negedge clock);
    checks++; if (miss_ready !== 1'b1) begin fails++; $display("FAIL dup_freed got %0b want 1", miss_ready); end
    tick();
    idle();
  endtask

  task automatic test_store_hold();
    do_reset();
    idle();
    dcache_wr_ready = 1'b0;
    miss_valid = 1'b1;
    miss_addr = 32'h2002;
    miss_is_store = 1'b1;
    miss_st_size = 2'd1;
    miss_st_data = 32'h1234;
    tick();
    idle();
    dcache_wr_ready = 1'b0;
    mem2proc_transaction_tag = 4'd7;
    tick();
    mem2proc_transaction_tag = 4'd0;
    mem2proc_data_tag = 4'd7;
    mem2proc_data = 64'hDEAD_BEEF_0123_4567;
    @(negedge clock);
    checks++; if (mshr2Dcache_wr !== 1'b0) begin fails++; $display("FAIL store_wr_nogrant got %0b want 0", mshr2Dcache_wr); end
    tick();
    mem2proc_data_tag = 4'd0;
    mem2proc_data = 64'd0;
    for (int k = 0; k < 4; k++) begin
      if (k == 3) dcache_wr_ready = 1'b1;
      @(negedge clock);
      checks++; if (mshr2Dcache_wr !== 1'b1 || mshr2Dcache_mem_block !== 64'hDEAD_BEEF_0123_4567) begin fails++; $display("FAIL store_hold%0d got %0b/%h want 1/deadbeef01234567", k, mshr2Dcache_wr, mshr2Dcache_mem_block); end
      checks++; if (mshr2Dcache_addr !== 32'h2002 || mshr2Dcache_is_store !== 1'b1) begin fails++; $display("FAIL store_fields%0d got %h/%0b want 2002/1", k, mshr2Dcache_addr, mshr2Dcache_is_store); end
      checks++; if (mshr2Dcache_st_size !== 2'd1 || mshr2Dcache_st_data !== 32'h1234) begin fails++; $display("FAIL store_data%0d got %0d/%h want 1/1234", k, mshr2Dcache_st_size, mshr2Dcache_st_data); end
      tick();
    end
    @(negedge clock);
    checks++; if (mshr2Dcache_wr !== 1'b0 || mshr_empty !== 1'b1) begin fails++; $display("FAIL store_done got %0b/%0b want 0/1", mshr2Dcache_wr, mshr_empty); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    load_miss(32'h300);
    tick();
    load_miss(32'h400);
    mem2proc_transaction_tag = 4'd4;
    tick();
    idle();
    mem2proc_transaction_tag = 4'd6;
    tick();
    idle();
    @(negedge clock);
    checks++; if (mshr_empty !== 1'b0) begin fails++; $display("FAIL mid_busy got %0b want 0", mshr_empty); end
    tick();
    reset = 1'b0;
    #1;
    checks++; if (mshr_empty !== 1'b1) begin fails++; $display("FAIL mid_async_empty got %0b want 1", mshr_empty); end
    tick();
    reset = 1'b1;
    mem2proc_data_tag = 4'd4;
    mem2proc_data = 64'h44;
    @(negedge clock);
    checks++; if (mshr2Dcache_wr !== 1'b0) begin fails++; $display("FAIL mid_wr_data got %0b want 0", mshr2Dcache_wr); end
    tick();
    idle();
    @(negedge clock);
    checks++; if (mshr2Dcache_wr !== 1'b0 || mshr_empty !== 1'b1) begin fails++; $display("FAIL mid_after got %0b/%0b want 0/1", mshr2Dcache_wr, mshr_empty); end
  endtask

  task automatic test_random();
    int iss, cap, fil, fre, r;
    bit fwd, free_any, dup, e_ready, e_empty, e_wr;
    logic [1:0]  e_cmd, f_sz;
    logic [31:0] e_paddr, f_addr, f_sd;
    logic [63:0] f_blk;
    logic        f_st;
    logic [3:0]  t, ttag;
    int wd[$];
    do_reset();
    for (int i = 0; i < N; i++) ms[i] = S_FREE;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      miss_valid = ($urandom_range(0, 1) == 1);
      miss_addr = 32'h4000 + 32'($urandom_range(0, 15)) * 8 + 32'($urandom_range(0, 7));
      miss_is_store = ($urandom_range(0, 1) == 1);
      miss_st_size = 2'($urandom_range(0, 2));
      miss_st_data = $urandom();
      dcache_wr_ready = ($urandom_range(0, 1) == 1);
      mem2proc_data = {$urandom(), $urandom()};
      mem2proc_data_tag = 4'd0;
      wd.delete();
      for (int i = 0; i < N; i++) if (ms[i] == S_DATA) wd.push_back(i);
      r = int'($urandom_range(0, 7));
      if (r < 4 && wd.size() > 0)
        mem2proc_data_tag = mt[wd[$urandom_range(0, wd.size() - 1)]];
      else if (r == 4) begin
        t = 4'($urandom_range(1, 15));
        if (!held(t)) mem2proc_data_tag = t;
      end
      iss = -1; cap = -1; fil = -1;
      free_any = 0; dup = 0; e_empty = 1;
      for (int i = 0; i < N; i++) begin
        if (ms[i] == S_FREE) free_any = 1;
        else begin
          e_empty = 0;
          if (ma[i][31:3] == miss_addr[31:3]) dup = 1;
        end
        if (ms[i] == S_ISSUE && iss < 0) iss = i;
        if (ms[i] == S_DATA && cap < 0 && mem2proc_data_tag != 0 && mt[i] == mem2proc_data_tag) cap = i;
        if (ms[i] == S_READY && fil < 0) fil = i;
      end
      fwd = FWD && fil < 0 && cap >= 0 && dcache_wr_ready;
      e_ready = free_any && !dup;
      e_cmd = (iss >= 0) ? 2'd1 : 2'd0;
      e_paddr = (iss >= 0) ? {ma[iss][31:3], 3'b000} : 32'd0;
      e_wr = (fil >= 0) || fwd;
      f_addr = 0; f_st = 0; f_sz = 0; f_sd = 0; f_blk = 0;
      if (fil >= 0) begin
        f_addr = ma[fil]; f_st = mst[fil]; f_sz = msz[fil]; f_sd = msd[fil]; f_blk = mb[fil];
      end else if (fwd) begin
        f_addr = ma[cap]; f_st = mst[cap]; f_sz = msz[cap]; f_sd = msd[cap]; f_blk = mem2proc_data;
      end
      ttag = 4'd0;
      if (iss >= 0) begin
        if ($urandom_range(0, 2) != 0) begin
          if (cap >= 0 && $urandom_range(0, 3) == 0) ttag = mem2proc_data_tag;
          else for (int k = 0; k < 64 && ttag == 4'd0; k++) begin
            t = 4'($urandom_range(1, 15));
            if (!held(t)) ttag = t;
          end
        end
      end else ttag = 4'($urandom_range(0, 15));
      mem2proc_transaction_tag = ttag;
      @(negedge clock);
      checks++; if (miss_ready !== e_ready) begin fails++; $display("FAIL rnd_ready c%0d got %0b want %0b", cyc, miss_ready, e_ready); end
      checks++; if (mshr_empty !== e_empty) begin fails++; $display("FAIL rnd_empty c%0d got %0b want %0b", cyc, mshr_empty, e_empty); end
      checks++; if (proc2mem_command !== e_cmd || proc2mem_addr !== e_paddr) begin fails++; $display("FAIL rnd_issue c%0d got %0d/%h want %0d/%h", cyc, proc2mem_command, proc2mem_addr, e_cmd, e_paddr); end
      checks++; if (mshr2Dcache_wr !== e_wr) begin fails++; $display("FAIL rnd_wr c%0d got %0b want %0b", cyc, mshr2Dcache_wr, e_wr); end
      if (e_wr) begin
        checks++; if (mshr2Dcache_mem_block !== f_blk || mshr2Dcache_addr !== f_addr) begin fails++; $display("FAIL rnd_fill c%0d got %h/%h want %h/%h", cyc, mshr2Dcache_mem_block, mshr2Dcache_addr, f_blk, f_addr); end
        checks++; if (mshr2Dcache_is_store !== f_st || mshr2Dcache_st_size !== f_sz || mshr2Dcache_st_data !== f_sd) begin fails++; $display("FAIL rnd_st c%0d got %0b/%0d/%h want %0b/%0d/%h", cyc, mshr2Dcache_is_store, mshr2Dcache_st_size, mshr2Dcache_st_data, f_st, f_sz, f_sd); end
      end
      if (miss_valid && e_ready) begin
        fre = -1;
        for (int i = 0; i < N; i++) if (ms[i] == S_FREE && fre < 0) fre = i;
        ms[fre] = S_ISSUE; ma[fre] = miss_addr; mst[fre] = miss_is_store;
        msz[fre] = miss_st_size; msd[fre] = miss_st_data;
      end
      if (iss >= 0 && ttag != 4'd0) begin
        ms[iss] = S_DATA; mt[iss] = ttag;
      end
      if (cap >= 0) begin
        ms[cap] = fwd ? S_FREE : S_READY; mb[cap] = mem2proc_data;
      end
      if (fil >= 0 && dcache_wr_ready) ms[fil] = S_FREE;
      tick();
    end
    idle();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0;
    idle();
    test_reset();
    test_single_load();
    test_four_reject();
    test_out_of_order();
    test_duplicate();
    test_store_hold();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
